// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch prediction unit: branch-type encodings
// and the default values of the unit's parameters.
// -----------------------------------------------------------------------------
package branch_pkg;

    // Branch classification carried by resolved branches and stored in the BTB.
    typedef enum logic [1:0] {
        BR_COND   = 2'd0,
        BR_JUMP   = 2'd1,
        BR_CALL   = 2'd2,
        BR_RETURN = 2'd3
    } br_type_e;

    // Default parameter values.
    localparam int DEF_DATA_WIDTH    = 32;  // address / target width
    localparam int DEF_COUNTER_WIDTH = 2;   // PHT saturating counter width (1..4)
    localparam int DEF_NUM_ENTRIES   = 256; // PHT and BTB depth (power of two)
    localparam int DEF_HIST_WIDTH    = 8;   // global history length (1..IDX_W)
    localparam int DEF_RAS_DEPTH     = 8;   // return-address-stack depth (power of two)

endpackage : branch_pkg

// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
// Circular return-address stack. Pushing onto a full stack overwrites the
// oldest entry; popping an empty stack is ignored; push and pop together
// replace the top entry in place (or act as a plain push when empty).
//
// Ports:
//   clk         in   clock
//   rstn        in   asynchronous active-low reset
//   i_push      in   push i_push_addr
//   i_push_addr in   return address to push [DATA_WIDTH]
//   i_pop       in   pop top entry
//   o_top       out  current top entry (stale when o_empty is high)
//   o_empty     out  stack holds no entries
// -----------------------------------------------------------------------------
module return_address_stack
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_RAS_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_addr,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_top,
    output logic                  o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_ptr;   // next free slot; top lives one below
    logic [CNT_W-1:0]      r_cnt;   // number of valid entries, 0..DEPTH

    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_empty;
    logic             w_replace;
    logic [PTR_W-1:0] w_wr_idx;

    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
    assign w_empty   = (r_cnt == '0);
    assign w_replace = i_push && i_pop && !w_empty;
    assign w_wr_idx  = w_replace ? w_ptr_dec : r_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_replace) begin
            // Top is rewritten in place; pointer and count stay put.
        end else if (i_push) begin
            r_ptr <= w_ptr_inc;
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_pop && !w_empty) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; r_cnt alone defines which slots
    // are meaningful. The rstn qualifier drops writes on an edge held in reset.
    always_ff @(posedge clk) begin
        if (rstn && i_push) begin
            r_mem[w_wr_idx] <= i_push_addr;
        end
    end

    assign o_top   = r_mem[w_ptr_dec];
    assign o_empty = w_empty;

endmodule : return_address_stack

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
// Gshare direction predictor (PHT of saturating counters hashed with global
// history), direct-mapped BTB and a return-address stack. Lookup is purely
// combinational on pc and observes state as it was before the current edge.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   update_predictor     train PHT counter and shift history
//   update_btb           install resolved branch into BTB
//   actually_taken       resolved direction
//   resolved_pc          resolved branch address [DATA_WIDTH]
//   resolved_pc_target   resolved branch target  [DATA_WIDTH]
//   resolved_type        resolved branch type    [2] (br_type_e)
//   ras_push/_addr/pop   return-address-stack operations
//   pc                   lookup address          [DATA_WIDTH]
//   hit                  BTB hit for pc
//   pred                 predicted taken
//   branch_target        predicted target        [DATA_WIDTH]
//   is_return            hit entry is a return
//   ras_empty            return-address stack is empty
// -----------------------------------------------------------------------------
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int NUM_ENTRIES   = DEF_NUM_ENTRIES,
    parameter int HIST_WIDTH    = DEF_HIST_WIDTH,
    parameter int RAS_DEPTH     = DEF_RAS_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  update_predictor,
    input  logic                  update_btb,
    input  logic                  actually_taken,
    input  logic [DATA_WIDTH-1:0] resolved_pc,
    input  logic [DATA_WIDTH-1:0] resolved_pc_target,
    input  logic [1:0]            resolved_type,
    input  logic                  ras_push,
    input  logic [DATA_WIDTH-1:0] ras_push_addr,
    input  logic                  ras_pop,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit,
    output logic                  pred,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic                  is_return,
    output logic                  ras_empty
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] CTR_INIT =
        COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);  // weakly not-taken

    // Pattern history table and global history.
    logic [COUNTER_WIDTH-1:0] r_pht [NUM_ENTRIES];
    logic [HIST_WIDTH-1:0]    r_ghr;

    // Branch target buffer: valid bits reset, payload does not.
    logic [NUM_ENTRIES-1:0]   r_btb_valid;
    logic [TAG_W-1:0]         r_btb_tag    [NUM_ENTRIES];
    br_type_e                 r_btb_type   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]    r_btb_target [NUM_ENTRIES];

    logic [IDX_W-1:0]         w_ghr_ext;
    logic [IDX_W-1:0]         w_lk_idx;
    logic [IDX_W-1:0]         w_lk_pht_idx;
    logic [TAG_W-1:0]         w_lk_tag;
    logic [IDX_W-1:0]         w_up_idx;
    logic [IDX_W-1:0]         w_up_pht_idx;
    logic [TAG_W-1:0]         w_up_tag;
    logic [COUNTER_WIDTH-1:0] w_up_ctr;
    logic [COUNTER_WIDTH-1:0] w_up_ctr_next;
    logic                     w_hit;
    br_type_e                 w_lk_type;
    logic [DATA_WIDTH-1:0]    w_ras_top;
    logic                     w_ras_empty;
    logic                     w_unused;

    // Word-aligned addresses: the two low bits never take part in indexing.
    assign w_unused = ^{pc[1:0], resolved_pc[1:0]};

    // History is no wider than the index, so the cast zero-extends it.
    assign w_ghr_ext    = IDX_W'(r_ghr);
    assign w_lk_idx     = pc[IDX_W+1:2];
    assign w_lk_pht_idx = w_lk_idx ^ w_ghr_ext;
    assign w_lk_tag     = pc[DATA_WIDTH-1:IDX_W+2];
    assign w_up_idx     = resolved_pc[IDX_W+1:2];
    assign w_up_pht_idx = w_up_idx ^ w_ghr_ext;
    assign w_up_tag     = resolved_pc[DATA_WIDTH-1:IDX_W+2];
    assign w_up_ctr     = r_pht[w_up_pht_idx];

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_up_ctr_next = w_up_ctr;
        if (actually_taken) begin
            if (w_up_ctr != CTR_MAX) w_up_ctr_next = w_up_ctr + COUNTER_WIDTH'(1);
        end else begin
            if (w_up_ctr != '0) w_up_ctr_next = w_up_ctr - COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_pht[i] <= CTR_INIT;
            end
            r_ghr <= '0;
        end else if (update_predictor) begin
            r_pht[w_up_pht_idx] <= w_up_ctr_next;
            // Truncating {ghr, taken} keeps the newest HIST_WIDTH outcomes.
            r_ghr <= HIST_WIDTH'({r_ghr, actually_taken});
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_btb_valid <= '0;
        end else if (update_btb) begin
            r_btb_valid[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && update_btb) begin
            r_btb_tag[w_up_idx]    <= w_up_tag;
            r_btb_type[w_up_idx]   <= br_type_e'(resolved_type);
            r_btb_target[w_up_idx] <= resolved_pc_target;
        end
    end

    return_address_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (ras_push),
        .i_push_addr (ras_push_addr),
        .i_pop       (ras_pop),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

    assign w_hit     = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_type = r_btb_type[w_lk_idx];

    always_comb begin
        hit           = 1'b0;
        pred          = 1'b0;
        branch_target = '0;
        is_return     = 1'b0;
        if (w_hit) begin
            hit = 1'b1;
            unique case (w_lk_type)
                BR_COND: begin
                    pred          = r_pht[w_lk_pht_idx][COUNTER_WIDTH-1];
                    branch_target = r_btb_target[w_lk_idx];
                end
                BR_JUMP, BR_CALL: begin
                    pred          = 1'b1;
                    branch_target = r_btb_target[w_lk_idx];
                end
                BR_RETURN: begin
                    is_return     = 1'b1;
                    pred          = !w_ras_empty;
                    branch_target = w_ras_empty ? '0 : w_ras_top;
                end
                default: ;
            endcase
        end
    end

    assign ras_empty = w_ras_empty;

endmodule : branch_predict_unit

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed, table-driven bench for branch_predict_unit with default
// parameters. Each vector drives one cycle of inputs and lists the
// combinational outputs expected before that cycle's edge commits.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;
    import branch_pkg::*;

    logic        clk;
    logic        rstn;
    logic        update_predictor;
    logic        update_btb;
    logic        actually_taken;
    logic [31:0] resolved_pc;
    logic [31:0] resolved_pc_target;
    logic [1:0]  resolved_type;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] branch_target;
    logic        is_return;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    branch_predict_unit dut (
        .clk                (clk),
        .rstn               (rstn),
        .update_predictor   (update_predictor),
        .update_btb         (update_btb),
        .actually_taken     (actually_taken),
        .resolved_pc        (resolved_pc),
        .resolved_pc_target (resolved_pc_target),
        .resolved_type      (resolved_type),
        .ras_push           (ras_push),
        .ras_push_addr      (ras_push_addr),
        .ras_pop            (ras_pop),
        .pc                 (pc),
        .hit                (hit),
        .pred               (pred),
        .branch_target      (branch_target),
        .is_return          (is_return),
        .ras_empty          (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        up;
        logic        ub;
        logic        tk;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic [1:0]  rty;
        logic        push;
        logic [31:0] pa;
        logic        pop;
        logic [31:0] pc;
        logic        e_hit;
        logic        e_pred;
        logic [31:0] e_tgt;
        logic        e_ret;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic up, input logic ub, input logic tk,
        input logic [31:0] rpc, input logic [31:0] rtgt, input logic [1:0] rty,
        input logic push, input logic [31:0] pa, input logic pop,
        input logic [31:0] lpc,
        input logic e_hit, input logic e_pred, input logic [31:0] e_tgt,
        input logic e_ret, input logic e_empty);
        vec_t v;
        v.up = up; v.ub = ub; v.tk = tk; v.rpc = rpc; v.rtgt = rtgt; v.rty = rty;
        v.push = push; v.pa = pa; v.pop = pop; v.pc = lpc;
        v.e_hit = e_hit; v.e_pred = e_pred; v.e_tgt = e_tgt;
        v.e_ret = e_ret; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_hit, input logic e_pred,
                              input logic [31:0] e_tgt, input logic e_ret, input logic e_empty);
        check($sformatf("%s hit", tag),           32'(hit),       32'(e_hit));
        check($sformatf("%s pred", tag),          32'(pred),      32'(e_pred));
        check($sformatf("%s branch_target", tag), branch_target,  e_tgt);
        check($sformatf("%s is_return", tag),     32'(is_return), 32'(e_ret));
        check($sformatf("%s ras_empty", tag),     32'(ras_empty), 32'(e_empty));
    endtask

    task automatic drive_idle();
        update_predictor   = 1'b0;
        update_btb         = 1'b0;
        actually_taken     = 1'b0;
        resolved_pc        = '0;
        resolved_pc_target = '0;
        resolved_type      = '0;
        ras_push           = 1'b0;
        ras_push_addr      = '0;
        ras_pop            = 1'b0;
    endtask

    // Drive one vector after the falling edge, compare before the next rise.
    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        update_predictor   = v.up;
        update_btb         = v.ub;
        actually_taken     = v.tk;
        resolved_pc        = v.rpc;
        resolved_pc_target = v.rtgt;
        resolved_type      = v.rty;
        ras_push           = v.push;
        ras_push_addr      = v.pa;
        ras_pop            = v.pop;
        pc                 = v.pc;
        #1;
        check_outs(tag, v.e_hit, v.e_pred, v.e_tgt, v.e_ret, v.e_empty);
    endtask

    initial begin
        // up ub tk rpc rtgt type push pa pop | pc | hit pred tgt ret empty
        // Reset state and first conditional entry (ghr 0 -> 01 -> 11).
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0,0, 32'h100, 0,0,32'h0,  0,1));
        vecs.push_back(mk(0,1,0, 32'h100, 32'h200, BR_COND, 0,32'h0,0, 32'h100, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,1, 32'h100, 32'h0,   BR_COND, 0,32'h0,0, 32'h100, 1,0,32'h200,0,1));
        vecs.push_back(mk(1,0,1, 32'h100, 32'h0,   BR_COND, 0,32'h0,0, 32'h100, 1,0,32'h200,0,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0,0, 32'h100, 1,0,32'h200,0,1));
        // Five taken updates all aimed at PHT entry 0x10 (rpc idx = 0x10 ^ ghr).
        vecs.push_back(mk(1,0,1, 32'h4C,  32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,1, 32'h5C,  32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,1, 32'h7C,  32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,1, 32'h3C,  32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,1, 32'hBC,  32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        // ghr 0x7F: pc 0x1BC hashes to 0x10 (counter 3) -> pred 1.
        vecs.push_back(mk(0,1,0, 32'h1BC, 32'h777, BR_COND, 0,32'h0,0, 32'h1BC, 0,0,32'h0,  0,1));
        vecs.push_back(mk(1,0,0, 32'h1BC, 32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 1,1,32'h777,0,1));
        vecs.push_back(mk(1,0,0, 32'h3B8, 32'h0,   BR_COND, 0,32'h0,0, 32'h1BC, 1,0,32'h777,0,1));
        // ghr 0xFC: pc 0x3B0 hashes to 0x10 (counter 1) -> pred 0.
        vecs.push_back(mk(0,1,0, 32'h3B0, 32'h888, BR_COND, 0,32'h0,0, 32'h3B0, 0,0,32'h0,  0,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0,0, 32'h3B0, 1,0,32'h888,0,1));
        // Jump and call force pred.
        vecs.push_back(mk(0,1,0, 32'h600, 32'h650, BR_JUMP, 0,32'h0,0, 32'h600, 0,0,32'h0,  0,1));
        vecs.push_back(mk(0,1,0, 32'h704, 32'h740, BR_CALL, 0,32'h0,0, 32'h600, 1,1,32'h650,0,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0,0, 32'h704, 1,1,32'h740,0,1));
        // Return entry with RAS push/pop, pop on empty, push+pop replace.
        vecs.push_back(mk(0,1,0, 32'h300, 32'h0,   BR_RETURN,0,32'h0,0, 32'h300, 0,0,32'h0, 0,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 1,32'hA0,0, 32'h300, 1,0,32'h0,  1,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 1,32'hB0,0, 32'h300, 1,1,32'hA0, 1,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 1, 32'h300, 1,1,32'hB0, 1,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 1, 32'h300, 1,1,32'hA0, 1,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 1, 32'h300, 1,0,32'h0,  1,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 1,32'h11,1, 32'h300, 1,0,32'h0,  1,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 1,32'h22,1, 32'h300, 1,1,32'h11, 1,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 1, 32'h300, 1,1,32'h22, 1,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 0, 32'h300, 1,0,32'h0,  1,1));
        // All three update paths together; 0x500 aliases 0x100 in the BTB.
        vecs.push_back(mk(1,1,1, 32'h500, 32'h550, BR_JUMP, 1,32'h33,0, 32'h100, 1,0,32'h200,0,1));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 0, 32'h100, 0,0,32'h0,  0,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 0, 32'h500, 1,1,32'h550,0,0));
        vecs.push_back(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0, 0, 32'h300, 1,1,32'h33, 1,0));

        drive_idle();
        pc   = 32'h100;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

        // RAS overflow: stack holds 0x33, push 0x10..0x90, keep newest eight.
        for (int i = 0; i < 9; i++) begin
            run(mk(0,0,0, 32'h0, 32'h0, BR_COND, 1, 32'((i + 1) * 16), 0, 32'h300,
                   1, 1, (i == 0) ? 32'h33 : 32'(i * 16), 1, 0), $sformatf("ovf_push%0d", i));
        end
        for (int j = 0; j < 8; j++) begin
            run(mk(0,0,0, 32'h0, 32'h0, BR_COND, 0, 32'h0, 1, 32'h300,
                   1, 1, 32'(16'h90 - j * 16), 1, 0), $sformatf("ovf_pop%0d", j));
        end
        run(mk(0,0,0, 32'h0, 32'h0, BR_COND, 0,32'h0,0, 32'h300, 1,0,32'h0,1,1), "ovf_empty");

        // Asynchronous reset mid-sequence, with updates presented during reset.
        run(mk(0,0,0, 32'h0, 32'h0, BR_COND, 1,32'h44,0, 32'h500, 1,1,32'h550,0,1), "pre_rst");
        @(negedge clk);
        #2;
        rstn               = 1'b0;
        update_predictor   = 1'b1;
        update_btb         = 1'b1;
        actually_taken     = 1'b1;
        resolved_pc        = 32'h900;
        resolved_pc_target = 32'h990;
        resolved_type      = BR_JUMP;
        ras_push           = 1'b1;
        ras_push_addr      = 32'h55;
        pc                 = 32'h500;
        #1;
        check_outs("async_rst", 0, 0, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check_outs("in_rst", 0, 0, 32'h0, 0, 1);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;
        pc   = 32'h900;
        #1;
        check_outs("post_rst_900", 0, 0, 32'h0, 0, 1);
        pc = 32'h600;
        #1;
        check_outs("post_rst_600", 0, 0, 32'h0, 0, 1);
        pc = 32'h300;
        #1;
        check_outs("post_rst_300", 0, 0, 32'h0, 0, 1);

        // PHT re-initialised and history cleared: entry 0x40 is back to 1.
        run(mk(0,1,0, 32'h100, 32'h200, BR_COND, 0,32'h0,0, 32'h100, 0,0,32'h0,  0,1), "rst_btb");
        run(mk(1,0,1, 32'h100, 32'h0,   BR_COND, 0,32'h0,0, 32'h100, 1,0,32'h200,0,1), "rst_pht40");
        run(mk(0,1,0, 32'h104, 32'h208, BR_COND, 0,32'h0,0, 32'h100, 1,0,32'h200,0,1), "rst_ghr1");
        run(mk(0,0,0, 32'h0,   32'h0,   BR_COND, 0,32'h0,0, 32'h104, 1,1,32'h208,0,1), "rst_hash");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_branch_predict_unit

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/target width.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 2, PHT saturating-counter width (legal 1..4).
REQ-003 SHALL have parameter NUM_ENTRIES, default 256, PHT and BTB depth (power of two, IDX_W = log2).
REQ-004 SHALL have parameter HIST_WIDTH, default 8, global history length (legal 1..IDX_W).
REQ-005 SHALL have parameter RAS_DEPTH, default 8, return-address-stack depth (power of two).
REQ-006 SHALL have ports: clk  in  1  clock; rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have update inputs: update_predictor 1, update_btb 1, actually_taken 1, resolved_pc DATA_WIDTH, resolved_pc_target DATA_WIDTH, resolved_type 2 (0 cond, 1 jump, 2 call, 3 return).
REQ-008 SHALL have RAS inputs: ras_push 1, ras_push_addr DATA_WIDTH (return address), ras_pop 1.
REQ-009 SHALL have access input pc DATA_WIDTH and outputs hit 1, pred 1, branch_target DATA_WIDTH, is_return 1, ras_empty 1.

Function
REQ-010 SHALL index PHT with (pc[IDX_W+1:2] XOR zero-extended ghr); updates use the same hash on resolved_pc with the current ghr.
REQ-011 SHALL predict combinationally in the same cycle: pred = MSB of indexed counter; all state writes on rising clk edge; same-cycle lookup sees pre-update state.
REQ-012 SHALL on update_predictor saturate-increment counter if actually_taken else saturate-decrement; no wrap at 0 or 2^COUNTER_WIDTH-1.
REQ-013 SHALL on update_predictor shift ghr <= {ghr[HIST_WIDTH-2:0], actually_taken}.
REQ-014 SHALL hold a direct-mapped BTB entry {valid, tag = pc[DATA_WIDTH-1:IDX_W+2], type, target}, indexed by pc[IDX_W+1:2].
REQ-015 SHALL on update_btb write valid=1, tag, type, target from resolved_* into entry of resolved_pc, overwriting any prior occupant.
REQ-016 SHALL assert hit when indexed entry valid and tag matches; otherwise hit=0, pred=0, branch_target=0, is_return=0.
REQ-017 SHALL on hit with type jump or call force pred=1; type cond uses PHT.
REQ-018 SHALL on hit with type return drive is_return=1, branch_target = RAS top, pred = !ras_empty; if RAS empty branch_target=0.
REQ-019 SHALL implement RAS as circular buffer with pointer and count (0..RAS_DEPTH); ras_empty = (count==0).
REQ-020 SHALL on ras_push alone write addr at top; when full, overwrite oldest (pointer wraps, count stays RAS_DEPTH).
REQ-021 SHALL on ras_pop alone with count>0 decrement pointer and count; on pop when empty hold state.
REQ-022 SHALL on simultaneous ras_push and ras_pop replace top in place (count unchanged); if empty, behave as push only.
REQ-023 SHALL treat update_predictor and update_btb independently; both may assert in one cycle with RAS ops.

Reset
REQ-024 SHALL on rstn low asynchronously clear: all PHT counters to 2^(COUNTER_WIDTH-1)-1 (weakly not-taken), all BTB valid bits 0, ghr 0, RAS pointer and count 0.
REQ-025 SHALL drive outputs after reset: hit=0, pred=0, branch_target=0, is_return=0, ras_empty=1.
REQ-026 SHALL abandon any update whose edge coincides with rstn low; no partial writes.

Structure
REQ-027 SHALL place branch-type encodings (BR_COND, BR_JUMP, BR_CALL, BR_RETURN) and default parameter constants in shared package branch_pkg.
REQ-028 SHALL implement RAS as sub-module return_address_stack; PHT/BTB stay in the top module.

Verification
REQ-029 Reset, then pc=0x100 -> hit=0, pred=0, branch_target=0, ras_empty=1.
REQ-030 update_btb with resolved_pc=0x100, target=0x200, type cond; two update_predictor taken -> pc=0x100 gives hit=1, branch_target=0x200; pred per counter at hashed index (ghr=2'b11 changes index; verify entry 0x40^0x03).
REQ-031 Counter saturation: 5 taken updates same index -> counter 3, pred=1; 2 not-taken -> counter 1, pred=0.
REQ-032 RAS: push 0xA0,0xB0; return entry hit at 0x300 -> branch_target=0xB0, pred=1; pop -> 0xA0; pop twice -> ras_empty=1, pred=0, target 0.
REQ-033 RAS overflow: push 9 addresses 0x10..0x90 (depth 8) then pop 8 -> targets 0x90..0x20, then ras_empty=1.
REQ-034 Aliasing: update_btb pc=0x100 then pc=0x500 (same index) -> pc=0x100 hit=0, pc=0x500 hit=1; assert rstn mid-sequence -> all hits 0 next cycle.
